voice_gen: RTL and testbench



---
 rtl/voice_gen.sv | 126 ++++++++++++
 tb/tb_voice_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_gen.sv
// Time-multiplexed oscillator for the 16 voices: per-voice phase accumulators and
// noise LFSRs, one raw 10-bit sample returned per start request.
module voice_gen #(
    parameter int unsigned NUM_VOICES = 16,
    parameter logic [22:0] LFSR_SEED  = 23'h7FFFF8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  voice_idx_i,
    input  logic [15:0] freq_i,
    input  logic [11:0] pw_i,
    input  logic [3:0]  wave_i,
    output logic        ready_o,
    output logic [9:0]  wave_o
);

    typedef enum logic [1:0] {IDLE, UPDATE, OUTPUT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] freq_q, freq_d;
    logic [11:0] pw_q, pw_d;
    logic [3:0]  wave_sel_q, wave_sel_d;
    logic        ready_q, ready_d;
    logic [9:0]  wave_q, wave_d;

    logic [23:0] acc_q  [NUM_VOICES];
    logic [22:0] lfsr_q [NUM_VOICES];

    logic        voice_valid;
    logic [23:0] acc_rd, acc_sum;
    logic [22:0] lfsr_rd, lfsr_next;
    logic        state_we;
    logic [9:0]  saw, tri_w, pulse, noise, shaped;

    assign voice_valid = 32'(idx_q) < NUM_VOICES;
    assign acc_rd      = voice_valid ? acc_q[idx_q]  : '0;
    assign lfsr_rd     = voice_valid ? lfsr_q[idx_q] : LFSR_SEED;
    assign acc_sum     = acc_rd + {8'd0, freq_q};

    // The LFSR is clocked once per rising crossing of accumulator bit 19.
    assign lfsr_next = (!acc_rd[19] && acc_sum[19])
                     ? {lfsr_rd[21:0], lfsr_rd[22] ^ lfsr_rd[17]}
                     : lfsr_rd;

    // In OUTPUT the read ports already see the values written during UPDATE.
    assign saw   = acc_rd[23:14];
    assign tri_w = acc_rd[23] ? ~acc_rd[22:13] : acc_rd[22:13];
    assign pulse = (acc_rd[23:12] >= pw_q) ? '1 : '0;
    assign noise = {lfsr_rd[22], lfsr_rd[20], lfsr_rd[16], lfsr_rd[13],
                    lfsr_rd[11], lfsr_rd[7],  lfsr_rd[4],  lfsr_rd[2], 2'b00};

    always_comb begin
        shaped = '1;
        if (wave_sel_q[0]) shaped = shaped & tri_w;
        if (wave_sel_q[1]) shaped = shaped & saw;
        if (wave_sel_q[2]) shaped = shaped & pulse;
        if (wave_sel_q[3]) shaped = shaped & noise;
        if (wave_sel_q == 4'd0) shaped = '0;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        freq_d     = freq_q;
        pw_d       = pw_q;
        wave_sel_d = wave_sel_q;
        ready_d    = 1'b0;
        wave_d     = wave_q;
        state_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    idx_d      = voice_idx_i;
                    freq_d     = freq_i;
                    pw_d       = pw_i;
                    wave_sel_d = wave_i;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                state_we = voice_valid;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                ready_d = 1'b1;
                wave_d  = voice_valid ? shaped : '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            freq_q     <= '0;
            pw_q       <= '0;
            wave_sel_q <= '0;
            ready_q    <= 1'b0;
            wave_q     <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                acc_q[v]  <= '0;
                lfsr_q[v] <= LFSR_SEED;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            freq_q     <= freq_d;
            pw_q       <= pw_d;
            wave_sel_q <= wave_sel_d;
            ready_q    <= ready_d;
            wave_q     <= wave_d;
            if (state_we) begin
                acc_q[idx_q]  <= acc_sum;
                lfsr_q[idx_q] <= lfsr_next;
            end
        end
    end

    assign ready_o = ready_q;
    assign wave_o  = wave_q;

endmodule

// File: tb/tb_voice_gen.sv
// Randomised self-checking bench for voice_gen against an arithmetic per-voice model
// that also tracks request acceptance and ready timing.
module tb_voice_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [3:0]  voice_idx_i;
    logic [15:0] freq_i;
    logic [11:0] pw_i;
    logic [3:0]  wave_i;
    logic        ready_o;
    logic [9:0]  wave_o;

    voice_gen #(.NUM_VOICES(16), .LFSR_SEED(23'h7FFFF8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .voice_idx_i (voice_idx_i),
        .freq_i      (freq_i),
        .pw_i        (pw_i),
        .wave_i      (wave_i),
        .ready_o     (ready_o),
        .wave_o      (wave_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    localparam int unsigned SEED = 32'h7FFFF8;

    function automatic int unsigned lfsr_step(input int unsigned l);
        return ((l * 2) % 32'h800000) + (((l / 32'h400000) + (l / 32'h20000)) % 2);
    endfunction

    function automatic logic [9:0] shape(input int unsigned a, input int unsigned l,
                                         input int unsigned pw, input int unsigned w);
        int unsigned taps [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
        int unsigned saw, tri_v, pulse, noise, r;
        saw   = a / 16384;
        tri_v = (a / 8192) % 1024;
        if (a >= 32'h800000) tri_v = 1023 - tri_v;
        pulse = ((a / 4096) >= pw) ? 1023 : 0;
        noise = 0;
        for (int k = 0; k < 8; k++) noise = noise * 2 + ((l >> taps[k]) % 2);
        noise = noise * 4;
        r = 1023;
        if (w % 2 == 1)       r = r & tri_v;
        if ((w / 2) % 2 == 1) r = r & saw;
        if ((w / 4) % 2 == 1) r = r & pulse;
        if ((w / 8) % 2 == 1) r = r & noise;
        if (w == 0) r = 0;
        return 10'(r);
    endfunction

    // Reference model: a request is accepted when idle; the sample appears two edges later.
    int unsigned m_acc  [16];
    int unsigned m_lfsr [16];
    int          m_busy;
    logic        m_ready;
    logic [9:0]  m_pend, m_wave;
    int unsigned mv, m_old, m_new;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int v = 0; v < 16; v++) begin
                m_acc[v]  = 0;
                m_lfsr[v] = SEED;
            end
            m_busy  = 0;
            m_ready = 1'b0;
            m_wave  = '0;
        end else begin
            m_ready = 1'b0;
            if (m_busy == 2) begin
                m_busy = 1;
            end else if (m_busy == 1) begin
                m_busy  = 0;
                m_ready = 1'b1;
                m_wave  = m_pend;
            end else if (start_i === 1'b1) begin
                mv    = voice_idx_i;
                m_old = m_acc[mv];
                m_new = (m_old + freq_i) % 32'h1000000;
                m_acc[mv] = m_new;
                if (((m_old >> 19) % 2 == 0) && ((m_new >> 19) % 2 == 1))
                    m_lfsr[mv] = lfsr_step(m_lfsr[mv]);
                m_pend = shape(m_new, m_lfsr[mv], pw_i, wave_i);
                m_busy = 2;
            end
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check_eq("ready", ready_o, m_ready);
            if (m_ready) check_eq("wave", wave_o, m_wave);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic req(input int v, input int f, input int p, input int w,
                       output logic [9:0] res, output int lat);
        start_i     = 1'b1;
        voice_idx_i = 4'(v);
        freq_i      = 16'(f);
        pw_i        = 12'(p);
        wave_i      = 4'(w);
        tick();
        start_i     = 1'b0;
        voice_idx_i = 4'($urandom);
        freq_i      = 16'($urandom);
        pw_i        = 12'($urandom);
        wave_i      = 4'($urandom);
        lat = 1;
        while (lat < 10 && ready_o !== 1'b1) begin
            tick();
            lat++;
        end
        res = wave_o;
        if (lat >= 10) check_eq("ready_timeout", 0, 1);
    endtask

    logic [9:0]  res;
    int          lat;
    int unsigned a9, exp9, tri9, ra, rl;
    logic [9:0]  noise_got [9];
    int unsigned mask, pulses;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; voice_idx_i = '0; freq_i = '0; pw_i = '0; wave_i = '0;
        repeat (2) tick();
        check_eq("reset_ready", ready_o, 0);
        check_eq("reset_wave", wave_o, 0);
        rst_i = 1'b0;
        tick();

        req(3, 16'hFFFF, 0, 4'b0010, res, lat);
        check_eq("v3_saw", res, 10'h003);
        check_eq("latency", lat, 3);
        req(3, 16'hFFFF, 0, 4'b0001, res, lat);
        check_eq("v3_tri", res, 10'h00F);

        for (int i = 1; i <= 257; i++) begin
            req(0, 16'hFFFF, 0, 4'b0010, res, lat);
            if (i == 256) check_eq("wrap_256", res, 10'h3FF);
            if (i == 257) check_eq("wrap_257", res, 10'h003);
        end

        for (int i = 1; i <= 32; i++) begin
            req(1, 16'h8000, 12'h010, 4'b0100, res, lat);
            if (i == 1)  check_eq("pulse_1", res, 10'h000);
            if (i == 2)  check_eq("pulse_2", res, 10'h3FF);
            if (i == 32) check_eq("pulse_32", res, 10'h3FF);
        end

        for (int i = 0; i < 9; i++) begin
            req(5, 16'hFFFF, 0, 4'b1000, res, lat);
            noise_got[i] = res;
            req(6, int'($urandom_range(0, 65535)), 0, 4'b1000, res, lat);
        end
        ra = 0; rl = SEED;
        for (int i = 0; i < 9; i++) begin
            m_old = ra;
            ra = (ra + 32'hFFFF) % 32'h1000000;
            if (((m_old >> 19) % 2 == 0) && ((ra >> 19) % 2 == 1)) rl = lfsr_step(rl);
            check_eq("noise_indep", noise_got[i], shape(ra, rl, 0, 8));
        end

        start_i = 1'b1; voice_idx_i = 4'd7; freq_i = 16'h1357; pw_i = '0; wave_i = 4'b0010;
        mask = 0; pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (ready_o === 1'b1) begin
                mask = mask | (32'd1 << k);
                pulses++;
            end
            if (k == 10) start_i = 1'b0;
        end
        check_eq("busy_pulses", pulses, 3);
        check_eq("busy_mask", mask, (32'd1 << 3) | (32'd1 << 6) | (32'd1 << 9));
        repeat (4) tick();

        a9 = 0;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom_range(0, 65535);
            req(9, int'(ra), 0, 4'b0011, res, lat);
            a9   = (a9 + ra) % 32'h1000000;
            tri9 = (a9 / 8192) % 1024;
            if (a9 >= 32'h800000) tri9 = 1023 - tri9;
            exp9 = (a9 / 16384) & tri9;
            check_eq("combine", res, exp9);
        end

        start_i = 1'b1; voice_idx_i = 4'd4; freq_i = 16'h1234; wave_i = 4'b0010;
        tick();
        start_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("no_ready_after_reset", ready_o, 0);
        end
        req(4, 16'hC000, 0, 4'b0010, res, lat);
        check_eq("post_reset_acc", res, 10'h003);

        for (int k = 0; k < 600; k++) begin
            start_i     = 1'($urandom_range(0, 1));
            voice_idx_i = 4'($urandom);
            freq_i      = 16'($urandom);
            pw_i        = 12'($urandom);
            wave_i      = 4'($urandom);
            tick();
        end
        start_i = 1'b0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
